mem_access_unit: RTL and testbench

- Memory-side stage directly downstream of the multi-cycle controller.
- Turns the controller's IorD / MemoryWrite / IRWrite strobes into a single-outstanding bus transaction with a req/ack handshake.
- Owns the instruction register (IR) and memory data register (MDR).
- Reports busy/done/err so the controller can hold its state counter on slow memory.

---
 rtl/mem_access_unit.sv | 213 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Memory-side stage behind the multi-cycle controller. Converts
//            the controller's IorD / MemoryWrite / IRWrite strobes into a
//            single-outstanding req/ack bus transaction and owns the
//            instruction register (ir) and memory data register (mdr).
// Ports    : clk, clr (async active-low reset)
//            go, IorD, IRWrite, MemoryWrite, func3, pc, alu_out, store_data
//                                  - controller request side
//            ir, mdr               - architectural capture registers
//            busy, done, err       - status back to the controller
//            bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
//            bus_rdata, bus_ack    - 32-bit, 4-lane memory bus
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            go,
    input  logic            IorD,
    input  logic            IRWrite,
    input  logic            MemoryWrite,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] mdr,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_wstrb,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] c_NOP     = XLEN'(32'h0000_0013);
    localparam logic [7:0]      c_TIMEOUT = 8'(TIMEOUT);
    localparam logic [1:0]      c_TGT_NONE = 2'd0;
    localparam logic [1:0]      c_TGT_IR   = 2'd1;
    localparam logic [1:0]      c_TGT_MDR  = 2'd2;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_size;
    logic        r_zext;
    logic [1:0]  r_off;
    logic [1:0]  r_tgt;

    logic [XLEN-1:0] w_eff_addr;
    logic [1:0]      w_size;
    logic            w_we;
    logic [1:0]      w_tgt;
    logic            w_misaligned;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_load_data;
    logic [7:0]      w_cnt_next;

    // Request decode, evaluated only when go is accepted in IDLE.
    // A fetch is always a full word regardless of func3.
    assign w_eff_addr = IorD ? alu_out : pc;
    assign w_size     = IorD ? func3[1:0] : 2'b10;
    assign w_we       = IorD & MemoryWrite;
    assign w_tgt      = (IRWrite & ~IorD)     ? c_TGT_IR  :
                        (IorD & ~MemoryWrite) ? c_TGT_MDR : c_TGT_NONE;
    assign w_cnt_next = r_cnt + 8'd1;

    always_comb begin
        w_misaligned = 1'b0;
        case (w_size)
            2'b01:   w_misaligned = w_eff_addr[0];
            2'b10:   w_misaligned = |w_eff_addr[1:0];
            2'b11:   w_misaligned = 1'b1;
            default: w_misaligned = 1'b0;
        endcase
    end

    // Store lane steering: narrow data is replicated across the lanes so the
    // strobes alone select which bytes memory actually updates.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = '0;
        if (w_we) begin
            case (w_size)
                2'b00: begin
                    w_wstrb = 4'b0001 << w_eff_addr[1:0];
                    w_wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    w_wstrb = 4'b0011 << w_eff_addr[1:0];
                    w_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = store_data;
                end
            endcase
        end
    end

    // Load extraction from the latched offset and size.
    assign w_shifted = bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_data = bus_rdata;
        case (r_size)
            2'b00: w_load_data = r_zext ? {24'd0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01: w_load_data = r_zext ? {16'd0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_size    <= 2'b00;
            r_zext    <= 1'b0;
            r_off     <= 2'b00;
            r_tgt     <= c_TGT_NONE;
            ir        <= c_NOP;
            mdr       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= 4'b0000;
        end else begin
            // Status pulses last a single cycle.
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_size <= w_size;
                        r_zext <= func3[2];
                        r_off  <= w_eff_addr[1:0];
                        r_tgt  <= w_tgt;
                        r_cnt  <= 8'd0;
                        if (w_misaligned) begin
                            // Rejected before the bus is touched.
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            r_state   <= S_BUS;
                            busy      <= 1'b1;
                            bus_req   <= 1'b1;
                            bus_we    <= w_we;
                            bus_addr  <= {w_eff_addr[XLEN-1:2], 2'b00};
                            bus_wdata <= w_wdata;
                            bus_wstrb <= w_wstrb;
                        end
                    end
                end
                S_BUS: begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (bus_ack) begin
                        case (r_tgt)
                            c_TGT_IR:  ir  <= bus_rdata;
                            c_TGT_MDR: mdr <= w_load_data;
                            default: ;
                        endcase
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        done    <= 1'b1;
                    end else if (w_cnt_next == c_TIMEOUT) begin
                        r_state <= S_DONE;
                        r_cnt   <= w_cnt_next;
                        busy    <= 1'b0;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. The bench plays the
//            memory, predicts each transaction's outcome from the access
//            rules (alignment, lanes, extension, latency, timeout) and keeps
//            its own copy of ir/mdr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            clr;
    logic            go;
    logic            IorD;
    logic            IRWrite;
    logic            MemoryWrite;
    logic [2:0]      func3;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] mdr;
    logic            busy;
    logic            done;
    logic            err;
    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic [3:0]      bus_wstrb;
    logic [XLEN-1:0] bus_rdata;
    logic            bus_ack;

    mem_access_unit #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .clr         (clr),
        .go          (go),
        .IorD        (IorD),
        .IRWrite     (IRWrite),
        .MemoryWrite (MemoryWrite),
        .func3       (func3),
        .pc          (pc),
        .alu_out     (alu_out),
        .store_data  (store_data),
        .ir          (ir),
        .mdr         (mdr),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_wstrb   (bus_wstrb),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_ir;
    logic [31:0] exp_mdr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, expv);
        end
    endtask

    // Load value as architecturally defined: pick the byte/half at the byte
    // offset, then sign- or zero-extend.
    function automatic logic [31:0] load_value(input logic [31:0] rd, input int off,
                                               input logic [2:0] f3);
        logic [31:0] v;
        case (f3[1:0])
            2'b00: begin
                v = (rd >> (8 * off)) & 32'hFF;
                if (!f3[2] && v >= 32'd128) v = v - 32'd256;
            end
            2'b01: begin
                v = (rd >> (8 * off)) & 32'hFFFF;
                if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // One complete transaction: go pulse, memory responder acking after
    // 'waits' request cycles (waits >= TIMEOUT means never), and checks.
    task automatic txn(input logic iord, input logic irw, input logic mw,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rdata,
                       input int waits);
        int          sz, off, exp_done, exp_req, reqs, dcyc;
        bit          mis, we, exp_err;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;

        sz  = iord ? int'(f3[1:0]) : 2;
        off = int'(addr % 4);
        mis = (sz == 3) || (sz == 1 && (addr % 2) != 0) || (sz == 2 && off != 0);
        we  = iord && mw;
        if (mis) begin
            exp_req = 0; exp_done = 1; exp_err = 1'b1;
        end else if (waits < TIMEOUT) begin
            exp_req = waits + 1; exp_done = waits + 2; exp_err = 1'b0;
        end else begin
            exp_req = TIMEOUT; exp_done = TIMEOUT + 1; exp_err = 1'b1;
        end
        exp_strb  = 4'b0000;
        exp_wdata = sdata;
        if (we) begin
            if (sz == 0) begin
                exp_strb  = 4'(1 << off);
                exp_wdata = (sdata & 32'hFF) * 32'h0101_0101;
            end else if (sz == 1) begin
                exp_strb  = 4'(3 << off);
                exp_wdata = (sdata & 32'hFFFF) * 32'h0001_0001;
            end else begin
                exp_strb  = 4'hF;
            end
        end

        @(negedge clk);
        go          = 1'b1;
        IorD        = iord;
        IRWrite     = irw;
        MemoryWrite = mw;
        func3       = f3;
        store_data  = sdata;
        if (iord) begin alu_out = addr; pc = $urandom; end
        else      begin pc = addr; alu_out = $urandom; end

        reqs = 0;
        dcyc = -1;
        for (int c = 1; c <= TIMEOUT + 8 && dcyc < 0; c++) begin
            @(negedge clk);
            go = 1'b0;
            if (bus_req) begin
                if (reqs == 0) begin
                    chk("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
                    chk("bus_we", 32'(bus_we), 32'(we));
                    chk("bus_wstrb", 32'(bus_wstrb), 32'(exp_strb));
                    chk("busy", 32'(busy), 32'd1);
                    if (we) chk("bus_wdata", bus_wdata, exp_wdata);
                end
                bus_ack   = (reqs == waits);
                bus_rdata = (reqs == waits) ? rdata : $urandom;
                reqs++;
            end else begin
                bus_ack = 1'b0;
            end
            if (done) begin
                dcyc = c;
                chk("err_with_done", 32'(err), 32'(exp_err));
                chk("busy_in_done", 32'(busy), 32'd0);
            end
        end
        bus_ack = 1'b0;
        chk("done_cycle", 32'(dcyc), 32'(exp_done));
        chk("req_cycles", 32'(reqs), 32'(exp_req));

        if (!exp_err) begin
            if (!iord && irw) exp_ir = rdata;
            if (iord && !mw)  exp_mdr = load_value(rdata, off, f3);
        end
        chk("ir", ir, exp_ir);
        chk("mdr", mdr, exp_mdr);

        @(negedge clk);
        chk("done_pulse_len", 32'(done), 32'd0);
        chk("err_pulse_len", 32'(err), 32'd0);
    endtask

    initial begin
        logic [2:0] f3_tab [7];
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b011};

        clr = 1'b0; go = 1'b0; IorD = 1'b0; IRWrite = 1'b0; MemoryWrite = 1'b0;
        func3 = 3'b000; pc = '0; alu_out = '0; store_data = '0;
        bus_rdata = '0; bus_ack = 1'b0;
        exp_ir  = 32'h0000_0013;
        exp_mdr = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_ir", ir, 32'h0000_0013);
        chk("rst_mdr", mdr, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_wstrb", 32'(bus_wstrb), 32'd0);
        clr = 1'b1;

        // Directed cases.
        txn(1'b0, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0050_0093, 2);   // fetch
        txn(1'b1, 1'b0, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_FFFF, 0);   // lb
        txn(1'b1, 1'b0, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_FFFF, 1);   // lbu
        txn(1'b1, 1'b0, 1'b1, 3'b001, 32'h302, 32'h1234_ABCD, 32'h0, 0);   // sh
        txn(1'b1, 1'b0, 1'b0, 3'b010, 32'h101, 32'h0, 32'h1111_1111, 0);   // misaligned lw
        txn(1'b1, 1'b0, 1'b0, 3'b011, 32'h100, 32'h0, 32'h2222_2222, 0);   // illegal size
        txn(1'b1, 1'b0, 1'b0, 3'b001, 32'h402, 32'h0, 32'h8001_7FFF, TIMEOUT - 1); // ack wins
        txn(1'b0, 1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h3333_3333, TIMEOUT + 4); // timeout

        // Late ack after the abort must not disturb anything.
        bus_rdata = 32'hDEAD_BEEF;
        bus_ack   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_req", 32'(bus_req), 32'd0);
            chk("late_ack_done", 32'(done), 32'd0);
        end
        bus_ack = 1'b0;
        chk("late_ack_ir", ir, exp_ir);
        chk("late_ack_mdr", mdr, exp_mdr);
        txn(1'b0, 1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h0010_0113, 0);

        // Reset in the middle of a bus transaction.
        @(negedge clk);
        go = 1'b1; IorD = 1'b0; IRWrite = 1'b1; MemoryWrite = 1'b0; pc = 32'h600;
        @(negedge clk);
        go = 1'b0;
        chk("pre_rst_req", 32'(bus_req), 32'd1);
        @(negedge clk);
        #2 clr = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus_req), 32'd0);
        chk("mid_rst_ir", ir, 32'h0000_0013);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        go = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_go_ignored", 32'(bus_req), 32'd0);
        go = 1'b0;
        clr = 1'b1;
        exp_ir  = 32'h0000_0013;
        exp_mdr = 32'h0;

        // Randomized mix of fetches, loads and stores.
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            int          w;
            f3 = f3_tab[$urandom_range(0, 6)];
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC | 32'($urandom_range(0, 1) * 2);
            w  = ($urandom_range(0, 9) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 4));
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                f3, a, $urandom, $urandom, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
